result_requant_writeback: RTL and testbench
===========================================

Name: result_requant_writeback

Overview:
- Drains accumulated 24-bit partial-sum rows from the results SRAM after the 1x64 vector-multiply pass.
- Requantizes each of the 64 lanes to signed 8-bit (round, arithmetic shift, optional ReLU, saturate) and packs them into one 512-bit activation word.
- Writes each packed word back into the unified buffer, so the next layer's pass can consume it directly.
- Sits downstream of the results SRAM and upstream of the unified buffer write port, alongside host writes, which are arbitrated by ub_ready.

Parameters:
- MATRIX_SIZE, 64, lanes per row.
- PARTIAL_SUM_BW, 24, signed width of each result lane.
- DATA_BW, 8, signed width of each output activation.
- ADDRESSSIZE, 10, address width of both the results SRAM and the unified buffer.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a drain; sampled only in IDLE.
- row_count  in  ADDRESSSIZE  number of rows to process; latched on start.
- src_base  in  ADDRESSSIZE  first results-SRAM address; latched on start.
- dst_base  in  ADDRESSSIZE  first unified-buffer address; latched on start.
- shift  in  5  right-shift amount; latched on start; values above 23 are clamped to 23.
- relu_en  in  1  when 1, negative lanes become 0; latched on start.
- res_rd_addr  out  ADDRESSSIZE  results-SRAM read address.
- res_rd_data  in  PARTIAL_SUM_BW*MATRIX_SIZE  read data, valid the cycle after res_rd_addr is presented.
- ub_ready  in  1  unified-buffer write port granted to this block.
- ub_we  out  1  unified-buffer write enable.
- ub_addr  out  ADDRESSSIZE  unified-buffer write address.
- ub_wdata  out  DATA_BW*MATRIX_SIZE  packed activation word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the drain completes.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; row index=0; ub_we=0, ub_addr=0, ub_wdata=0, res_rd_addr=0, busy=0, done=0. Reset has priority over every other input.
- Reset mid-drain aborts immediately. No further write is issued and done is not pulsed.
- FSM states: IDLE, RD, CAP, WR, FIN.
- IDLE:
  - start=1 latches all configuration inputs and sets index i=0.
  - If row_count=0, go to FIN; otherwise go to RD.
  - start while busy is ignored.
- RD: res_rd_addr = src_base+i (mod 2^ADDRESSSIZE); next state CAP.
- CAP:
  - res_rd_data is valid in this cycle.
  - All 64 lanes are requantized combinationally and registered into ub_wdata at the end of the cycle.
  - ub_addr is registered as dst_base+i (mod 2^ADDRESSSIZE).
  - Next state WR.
- WR:
  - ub_we = ub_ready (combinational on ub_ready, registered state). ub_addr and ub_wdata hold steady while ub_ready=0.
  - The write completes in the cycle where ub_ready=1.
  - On completion: if i = row_count-1, go to FIN; else i=i+1 and go to RD.
- FIN: done=1 for exactly one cycle; next state IDLE. busy drops to 0 in IDLE.
- Latency with ub_ready held high: a start in cycle 0 gives done in cycle 3N+1 for N≥1 rows, and in cycle 1 for N=0. ub_we is high in cycles 3, 6, …, 3N.
- Requantization, per lane k:
  - Input x = res_rd_data[24k+23:24k] (signed).
  - If relu_en and x<0, then x=0.
  - Extend x to 26 bits signed.
  - If s>0, add the round constant 1<<(s-1); then arithmetic-shift right by s (s = clamped shift).
  - Saturate the result to [-128,127].
  - Place the 8-bit result in ub_wdata[8k+7:8k].
- Address wrap: src_base+i and dst_base+i wrap modulo 2^ADDRESSSIZE; no error flag is raised.
- Outputs outside WR: ub_we=0. ub_wdata and ub_addr retain their last values.

Test Plan:
- Single row, all lanes 300, shift=2, relu_en=0, ub_ready=1 → start at cycle 0. Required: res_rd_addr=src_base at cycle 1; ub_we high only at cycle 3; every byte 0x4B (75); done pulses at cycle 4.
- Rounding and saturation, one row, shift=4:
  - Lane values 7, 8, -8, -9, 5000, -5000, 0x7FFFFF, 0x800000.
  - Required bytes: 0, 1, 0, -1 (0xFF), 127, -128, 127, -128.
- ReLU, lanes -1000 and 1000, shift=3, relu_en=1 → required bytes 0 and 125.
- Four rows, src_base=1022, dst_base=1023, ub_ready=1:
  - Required read addresses: 1022, 1023, 0, 1.
  - Required write addresses: 1023, 0, 1, 2.
  - done at cycle 13.
- Back-pressure: two rows with ub_ready low for 5 cycles at the first WR. Required: ub_we stays 0 and ub_addr/ub_wdata are stable throughout; the first write lands on the cycle ub_ready rises; done is delayed by exactly 5 cycles.
- Control corner cases:
  - row_count=0 → done at cycle 1, no ub_we.
  - start during busy → ignored.
  - rst asserted during WR of row 2 of 4 → next cycle IDLE with all outputs 0, and no done pulse.

Source files
------------

// File: rtl/result_requant_writeback.sv
// Drains 64-lane partial-sum rows from the results SRAM, requantizes every lane to int8
// and writes the packed activation word into the unified buffer.
module result_requant_writeback #(
  parameter int MATRIX_SIZE    = 64,
  parameter int PARTIAL_SUM_BW = 24,
  parameter int DATA_BW        = 8,
  parameter int ADDRESSSIZE    = 10
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [ADDRESSSIZE-1:0]              row_count,
  input  logic [ADDRESSSIZE-1:0]              src_base,
  input  logic [ADDRESSSIZE-1:0]              dst_base,
  input  logic [4:0]                          shift,
  input  logic                                relu_en,
  output logic [ADDRESSSIZE-1:0]              res_rd_addr,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] res_rd_data,
  input  logic                                ub_ready,
  output logic                                ub_we,
  output logic [ADDRESSSIZE-1:0]              ub_addr,
  output logic [DATA_BW*MATRIX_SIZE-1:0]      ub_wdata,
  output logic                                busy,
  output logic                                done
);

  localparam int EXT_W = PARTIAL_SUM_BW + 2;
  localparam logic [4:0] SHIFT_MAX = 5'(PARTIAL_SUM_BW - 1);
  localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'((1 << (DATA_BW - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_LO = EXT_W'(-(1 << (DATA_BW - 1)));

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_t;

  state_t                           state_q;
  logic [ADDRESSSIZE-1:0]           idx_q, rows_q, src_q, dst_q;
  logic [4:0]                       shift_q;
  logic                             relu_q;
  logic [ADDRESSSIZE-1:0]           rd_addr_q, ub_addr_q;
  logic [DATA_BW*MATRIX_SIZE-1:0]   wdata_q, wdata_d;
  logic                             last_row;

  // Two guard bits keep the round-half-up addition from overflowing at +max.
  function automatic logic signed [EXT_W-1:0] round_shift(
    input logic signed [PARTIAL_SUM_BW-1:0] x,
    input logic [4:0]                       s,
    input logic                             relu
  );
    logic signed [EXT_W-1:0] v;
    logic signed [EXT_W-1:0] rnd;
    v = EXT_W'(x);
    if (relu && x < 0) v = '0;
    rnd = '0;
    if (s != 5'd0) rnd = EXT_W'(1) << (s - 5'd1);
    return (v + rnd) >>> s;
  endfunction

  function automatic logic [DATA_BW-1:0] saturate(input logic signed [EXT_W-1:0] v);
    if (v > SAT_HI) return SAT_HI[DATA_BW-1:0];
    if (v < SAT_LO) return SAT_LO[DATA_BW-1:0];
    return v[DATA_BW-1:0];
  endfunction

  always_comb begin
    wdata_d = '0;
    for (int k = 0; k < MATRIX_SIZE; k++)
      wdata_d[k*DATA_BW +: DATA_BW] = saturate(round_shift(
        $signed(res_rd_data[k*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]), shift_q, relu_q));
  end

  assign last_row = (idx_q == rows_q - ADDRESSSIZE'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rows_q    <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      rd_addr_q <= '0;
      ub_addr_q <= '0;
      wdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          rows_q  <= row_count;
          src_q   <= src_base;
          dst_q   <= dst_base;
          shift_q <= (shift > SHIFT_MAX) ? SHIFT_MAX : shift;
          relu_q  <= relu_en;
          idx_q   <= '0;
          if (row_count == '0) begin
            state_q <= FIN;
          end else begin
            rd_addr_q <= src_base;
            state_q   <= RD;
          end
        end
        RD: state_q <= CAP;
        CAP: begin
          wdata_q   <= wdata_d;
          ub_addr_q <= dst_q + idx_q;
          state_q   <= WR;
        end
        // Address and data stay parked until the buffer port is granted.
        WR: if (ub_ready) begin
          if (last_row) begin
            state_q <= FIN;
          end else begin
            idx_q     <= idx_q + ADDRESSSIZE'(1);
            rd_addr_q <= src_q + idx_q + ADDRESSSIZE'(1);
            state_q   <= RD;
          end
        end
        FIN: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_rd_addr = rd_addr_q;
  assign ub_addr     = ub_addr_q;
  assign ub_wdata    = wdata_q;
  assign ub_we       = (state_q == WR) && ub_ready;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);

endmodule

// File: tb/tb_result_requant_writeback.sv
// Bench for result_requant_writeback: hand-computed vector table, control corner
// sequences and randomized drains checked against a cycle-level reference model.
module tb_result_requant_writeback;
  localparam int MS = 64, PSB = 24, DB = 8, AS = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, relu_en, ub_ready, ub_we, busy, done;
  logic [AS-1:0]     row_count, src_base, dst_base, res_rd_addr, ub_addr;
  logic [4:0]        shift;
  logic [MS*PSB-1:0] res_rd_data;
  logic [MS*DB-1:0]  ub_wdata;

  logic [MS*PSB-1:0] mem [1024];

  result_requant_writeback dut (
    .clk(clk), .rst(rst), .start(start), .row_count(row_count), .src_base(src_base),
    .dst_base(dst_base), .shift(shift), .relu_en(relu_en), .res_rd_addr(res_rd_addr),
    .res_rd_data(res_rd_data), .ub_ready(ub_ready), .ub_we(ub_we), .ub_addr(ub_addr),
    .ub_wdata(ub_wdata), .busy(busy), .done(done));

  // Results SRAM: one-cycle read latency.
  always @(posedge clk) res_rd_data <= mem[res_rd_addr];

  int n_checks = 0, n_fail = 0;
  int act_done;
  logic [MS*DB-1:0] last_wdata;

  function automatic void chk(string nm, logic [511:0] act, logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [7:0] rq(input int x, input int sh, input bit relu);
    longint v;
    int s;
    s = (sh > 23) ? 23 : sh;
    v = longint'(x);
    if (relu && v < 0) v = 0;
    if (s > 0) v = v + (longint'(1) << (s - 1));
    v = v >>> s;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  function automatic logic [MS*DB-1:0] model_row(input logic [MS*PSB-1:0] r, input int sh, input bit relu);
    logic [MS*DB-1:0] o;
    logic signed [PSB-1:0] lane;
    for (int k = 0; k < MS; k++) begin
      lane = r[k*PSB +: PSB];
      o[k*DB +: DB] = rq(int'(lane), sh, relu);
    end
    return o;
  endfunction

  task automatic fill_row(input int a, input int x);
    logic [31:0] xv;
    xv = x;
    for (int k = 0; k < MS; k++) mem[a % 1024][k*PSB +: PSB] = xv[PSB-1:0];
  endtask

  // Runs one drain from start to idle, checking every cycle against the model:
  // write j lands 3 cycles after the previous one (plus any stall), done one cycle after the last.
  task automatic run_drain(input int n, input int src, input int dst, input int sh, input bit relu,
                           input int stall_row, input int stall_len, input bit poke_start);
    int wcyc[$], rdcyc[$], waddr[$];
    logic [MS*DB-1:0] wexp[$];
    int t, base, done_c, j_w, j_r, st_lo, st_hi;
    t = 0; st_lo = -1; st_hi = -1;
    for (int j = 0; j < n; j++) begin
      rdcyc.push_back(t + 1);
      base = t + 3;
      if (j == stall_row) begin
        st_lo = base; st_hi = base + stall_len; base = base + stall_len;
      end
      wcyc.push_back(base);
      waddr.push_back((dst + j) % 1024);
      wexp.push_back(model_row(mem[(src + j) % 1024], sh, relu));
      t = base;
    end
    done_c = (n == 0) ? 1 : t + 1;
    @(posedge clk); #1;
    start = 1'b1; row_count = AS'(n); src_base = AS'(src); dst_base = AS'(dst);
    shift = 5'(sh); relu_en = relu; ub_ready = 1'b1;
    j_w = 0; j_r = 0; act_done = -1;
    for (int c = 1; c <= done_c + 2; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      ub_ready = !(c >= st_lo && c < st_hi);
      if (poke_start && c == 2) begin
        start = 1'b1; row_count = 10'd0; src_base = ~src_base; dst_base = ~dst_base;
        shift = ~shift; relu_en = ~relu_en;
      end
      @(negedge clk);
      if (j_r < n && c == rdcyc[j_r]) begin
        chk("rd_addr", res_rd_addr, rdcyc.size() > 0 ? (src + j_r) % 1024 : 0);
        j_r++;
      end
      if (c >= st_lo && c < st_hi) begin
        chk("stall_we", ub_we, 0);
        chk("stall_addr", ub_addr, waddr[j_w]);
        chk("stall_data", ub_wdata, wexp[j_w]);
      end else if (j_w < n && c == wcyc[j_w]) begin
        chk("we", ub_we, 1);
        chk("wr_addr", ub_addr, waddr[j_w]);
        chk("wr_data", ub_wdata, wexp[j_w]);
        last_wdata = ub_wdata;
        j_w++;
      end else begin
        chk("we_idle", ub_we, 0);
      end
      chk("done", done, c == done_c);
      if (done) act_done = c;
      chk("busy", busy, c <= done_c);
    end
  endtask

  typedef struct {
    int         x;
    int         sh;
    bit         relu;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[16];

  initial begin
    int n, src, dst, sh, srow;
    bit relu;
    logic [31:0] rv;

    tbl[0]  = '{300, 2, 1'b0, 8'd75};
    tbl[1]  = '{7, 4, 1'b0, 8'h00};
    tbl[2]  = '{8, 4, 1'b0, 8'h01};
    tbl[3]  = '{-8, 4, 1'b0, 8'h00};
    tbl[4]  = '{-9, 4, 1'b0, 8'hFF};
    tbl[5]  = '{5000, 4, 1'b0, 8'h7F};
    tbl[6]  = '{-5000, 4, 1'b0, 8'h80};
    tbl[7]  = '{32'h7FFFFF, 4, 1'b0, 8'h7F};
    tbl[8]  = '{-32'sh800000, 4, 1'b0, 8'h80};
    tbl[9]  = '{-1000, 3, 1'b1, 8'h00};
    tbl[10] = '{1000, 3, 1'b1, 8'd125};
    tbl[11] = '{32'h7FFFFF, 31, 1'b0, 8'h01};
    tbl[12] = '{-32'sh800000, 23, 1'b0, 8'hFF};
    tbl[13] = '{-200, 0, 1'b0, 8'h80};
    tbl[14] = '{77, 0, 1'b0, 8'd77};
    tbl[15] = '{-5, 0, 1'b1, 8'h00};

    for (int a = 0; a < 1024; a++) mem[a] = '0;
    rst = 1'b1; start = 1'b0; row_count = '0; src_base = '0; dst_base = '0;
    shift = '0; relu_en = 1'b0; ub_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", ub_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", ub_addr, 0);
    chk("rst_wdata", ub_wdata, 0);
    chk("rst_rdaddr", res_rd_addr, 0);
    @(posedge clk); #1; rst = 1'b0;

    // Single row of 300 >> 2.
    fill_row(40, 300);
    run_drain(1, 40, 77, 2, 1'b0, -1, 0, 1'b0);
    chk("single_done_cyc", act_done, 4);
    chk("single_bytes", last_wdata, {MS{8'h4B}});

    // Vector table: every lane holds x, all bytes must equal the hand-computed value.
    for (int v = 0; v < 16; v++) begin
      fill_row(5, tbl[v].x);
      run_drain(1, 5, 9, tbl[v].sh, tbl[v].relu, -1, 0, 1'b0);
      chk($sformatf("tbl%0d_lane0", v), last_wdata[7:0], tbl[v].exp);
      chk($sformatf("tbl%0d_lane63", v), last_wdata[MS*DB-1 -: 8], tbl[v].exp);
    end

    // Address wrap over four rows.
    for (int j = 0; j < 4; j++) fill_row((1022 + j) % 1024, 100 * j - 150);
    run_drain(4, 1022, 1023, 1, 1'b0, -1, 0, 1'b0);
    chk("wrap_done_cyc", act_done, 13);

    // Back-pressure: first write held off five cycles.
    fill_row(200, 1234); fill_row(201, -777);
    run_drain(2, 200, 300, 0, 1'b0, 0, 5, 1'b0);
    chk("bp_done_cyc", act_done, 12);

    // Zero rows.
    run_drain(0, 10, 20, 0, 1'b0, -1, 0, 1'b0);
    chk("zero_done_cyc", act_done, 1);

    // Start while busy must be ignored.
    fill_row(50, 999); fill_row(51, -999); fill_row(52, 12345);
    run_drain(3, 50, 60, 3, 1'b0, -1, 0, 1'b1);
    chk("poke_done_cyc", act_done, 10);

    // Reset during the second row's write.
    @(posedge clk); #1;
    start = 1'b1; row_count = 10'd4; src_base = 10'd0; dst_base = 10'd100;
    shift = 5'd2; relu_en = 1'b0; ub_ready = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      rst = (c == 6);
      @(negedge clk);
      if (c == 3) chk("rst_mid_first_we", ub_we, 1);
      if (c == 7) begin
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_addr", ub_addr, 0);
        chk("rst_mid_wdata", ub_wdata, 0);
        chk("rst_mid_rdaddr", res_rd_addr, 0);
      end
      if (c >= 7) begin
        chk("rst_mid_we", ub_we, 0);
        chk("rst_mid_done", done, 0);
      end
    end

    // Randomized drains.
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 5);
      src = $urandom_range(0, 1023);
      dst = $urandom_range(0, 1023);
      sh = $urandom_range(0, 31);
      relu = 1'($urandom_range(0, 1));
      srow = $urandom_range(0, n);
      for (int j = 0; j < n; j++)
        for (int k = 0; k < MS; k++) begin
          rv = $urandom;
          if (rv[31]) rv = 32'($urandom_range(0, 4000)) - 32'd2000;
          mem[(src + j) % 1024][k*PSB +: PSB] = rv[PSB-1:0];
        end
      run_drain(n, src, dst, sh, relu, srow, $urandom_range(1, 4), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
